fetch_queue: RTL and testbench

Instruction fetch front-end of the 5-stage MIPS pipeline. It owns the PC, issues sequential word requests to a registered (1-cycle latency) instruction memory, and buffers returned words with their PC+4 in a small FIFO. It presents them to the IF/ID register through a valid/ready handshake, with ready being IF/ID write enable. Branch/jump redirects resolved in ID flush the queue and restart fetch.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared word width, PC step, reset PC default and the
// FIFO entry layout used by the fetch front-end.
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {instr, pc_plus4} entries
// with push/pop/clear control and full/empty/count status.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    fetch_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_tail] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop) r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC, fetch credit and redirect control for the IF stage.
// Define FETCH_PERF_EN to add stall/empty/redirect perf counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc_plus4,
    input  logic              out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_W-1:0] stall_cycles,
    output logic [WORD_W-1:0] empty_cycles,
    output logic [WORD_W-1:0] redirect_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_credit;
    logic              w_issue;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_occ;
    fetch_entry_t      w_head;
    fetch_entry_t      w_entry;

    assign w_pop    = out_valid & out_ready;
    assign w_push   = r_inflight & ~redirect;
    assign w_occ    = w_count + CW'(r_inflight) - CW'(w_pop);
    assign w_credit = w_full ? (w_pop & ~r_inflight)
                             : (w_occ < CW'(DEPTH));
    assign w_issue  = Reset & ~redirect & w_credit;
    // While a word is in flight, r_fetch_pc already holds its PC + 4
    assign w_entry  = '{instr: imem_data, pc_plus4: r_fetch_pc};

    assign imem_req     = w_issue;
    assign imem_addr    = r_fetch_pc;
    assign out_valid    = ~w_empty & ~redirect;
    assign out_instr    = out_valid ? w_head.instr : '0;
    assign out_pc_plus4 = out_valid ? w_head.pc_plus4 : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_fetch_pc <= r_fetch_pc + PC_INC;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cycles   <= '0;
            empty_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (!out_valid && !redirect && empty_cycles != '1)
                empty_cycles <= empty_cycles + 32'd1;
            if (redirect && redirect_count != '1)
                redirect_count <= redirect_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a 1-cycle ROM
// model where ROM[i] = i.
module tb_fetch_queue;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_data = 32'h0;
    logic        imem_req;
    logic        out_valid;
    logic [31:0] imem_addr;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] empty_cycles;
    logic [31:0] redirect_count;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4),
        .out_ready    (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .empty_cycles   (empty_cycles),
        .redirect_count (redirect_count)
`endif
    );

    always #5 Clk = ~Clk;

    // Unrequested cycles return junk so stray pushes become visible
    always @(posedge Clk)
        imem_data <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic sb_load(input logic [31:0] pc);
        sb.delete();
        for (int i = 0; i < 64; i++)
            sb.push_back('{instr: (pc >> 2) + 32'(i),
                           pc4: pc + 32'(4 * (i + 1))});
    endtask

    task automatic start(input logic rdy);
        Reset = 1'b0;
        redirect = 1'b0;
        out_ready = rdy;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: got %b/%h want 0/0", imem_req, imem_addr);
        end
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 0 || out_pc_plus4 !== 0) begin
            errors++;
            $display("FAIL reset_out: got %b/%h/%h want 0/0/0",
                     out_valid, out_instr, out_pc_plus4);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (stall_cycles !== 0 || empty_cycles !== 0 || redirect_count !== 0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0",
                     stall_cycles, empty_cycles, redirect_count);
        end
`endif
    endtask

    task automatic test_stream();
        sb_load(32'h0);
        start(1'b1);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge Clk);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_addr c%0d: got %b/%h want 1/%h",
                         c, imem_req, imem_addr, 4 * c);
            end
            checks++;
            if (out_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL stream_valid c%0d: got %b", c, out_valid);
            end
            if (!out_valid) begin
                checks++;
                if (out_instr !== 0 || out_pc_plus4 !== 0) begin
                    errors++;
                    $display("FAIL stream_zero c%0d: got %h/%h want 0/0",
                             c, out_instr, out_pc_plus4);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL stream_data c%0d: got %h/%h want %h/%h",
                             c, out_instr, out_pc_plus4, e.instr, e.pc4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        sb_load(32'h0);
        start(1'b1);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge Clk);
            out_ready = !(c >= 2 && c < 12);
            #1;
            if (c >= 4 && c < 12) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_req c%0d: got %b want 0", c, imem_req);
                end
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_gap c%0d: got %b want 1", c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL bp_data c%0d: got %h/%h want %h/%h",
                             c, out_instr, out_pc_plus4, e.instr, e.pc4);
                end
            end
        end
    endtask

    task automatic test_redirect();
        sb_load(32'h0);
        start(1'b1);
        redirect_pc = 32'h40;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge Clk);
            redirect = (c == 6);
            #1;
            if (c == 6) begin
                checks++;
                if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_cycle: got %b/%b want 0/0",
                             out_valid, imem_req);
                end
                sb_load(32'h40);
            end
            if (c == 7) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL redir_addr: got %b/%h want 1/40",
                             imem_req, imem_addr);
                end
            end
            if (c == 7 || c == 8 || c == 9) begin
                checks++;
                if (out_valid !== (c == 9)) begin
                    errors++;
                    $display("FAIL redir_bubble c%0d: got %b", c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL redir_data c%0d: got %h/%h want %h/%h",
                             c, out_instr, out_pc_plus4, e.instr, e.pc4);
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_redirect_full();
        sb_load(32'h0);
        start(1'b0);
        redirect_pc = 32'h100;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge Clk);
            out_ready = (c >= 9);
            redirect = (c == 8);
            #1;
            if (c == 7) begin
                checks++;
                if (out_valid !== 1'b1 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL full_hold: got %b/%b want 1/0",
                             out_valid, imem_req);
                end
            end
            if (c == 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_redir: got %b want 0", out_valid);
                end
                sb_load(32'h100);
            end
            if (c == 9) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL full_addr: got %b/%h want 1/100",
                             imem_req, imem_addr);
                end
            end
            if (c == 9 || c == 10 || c == 11) begin
                checks++;
                if (out_valid !== (c == 11)) begin
                    errors++;
                    $display("FAIL full_cleared c%0d: got %b", c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL full_data c%0d: got %h/%h want %h/%h",
                             c, out_instr, out_pc_plus4, e.instr, e.pc4);
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        sb_load(32'h0);
        start(1'b1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge Clk);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL arst_pre c%0d: got %h want %h",
                             c, out_instr, e.instr);
                end
            end
        end
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL arst_drop: got %b/%b/%h want 0/0/0",
                     out_valid, imem_req, imem_addr);
        end
        @(negedge Clk);
        Reset = 1'b1;
        sb_load(32'h0);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge Clk);
            #1;
            checks++;
            if (out_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL arst_valid c%0d: got %b", c, out_valid);
            end
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_instr, out_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL arst_data c%0d: got %h/%h want %h/%h",
                             c, out_instr, out_pc_plus4, e.instr, e.pc4);
                end
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        start(1'b1);
        redirect_pc = 32'h200;
        for (int c = 0; c < 23; c++) begin
            if (c > 0) @(negedge Clk);
            out_ready = !(c >= 4 && c <= 8);
            redirect = (c == 12 || c == 17);
        end
        #1;
        checks++;
        if (stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL perf_stall: got %0d want 5", stall_cycles);
        end
        checks++;
        if (empty_cycles !== 32'd6) begin
            errors++;
            $display("FAIL perf_empty: got %0d want 6", empty_cycles);
        end
        checks++;
        if (redirect_count !== 32'd2) begin
            errors++;
            $display("FAIL perf_redir: got %0d want 2", redirect_count);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 0 || empty_cycles !== 0 || redirect_count !== 0) begin
            errors++;
            $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0",
                     stall_cycles, empty_cycles, redirect_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
